// File: rtl/serial_tx.sv
// serial_tx: memory-mapped 8N1 UART transmitter.
// CPU stores to DATA push bytes into a TX FIFO; a shifter drains the FIFO
// onto a registered serial line. Loads return a status word.
//
// Bus handshake: a store is accepted in the cycle where sel & we are high.
// There is no wait state. A read (sel & !we) returns status combinationally.
// A DATA store on a full FIFO is dropped and sets the sticky overflow flag.
module serial_tx #(
   parameter int CLK_DIV    = 868,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sel,
   input  logic        we,
   input  logic [3:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] dout,
   output logic        tx
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // Shifter state and its next-state values
   state_t           state;
   state_t           state_n;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_n;
   logic [2:0]       bit_q;
   logic [2:0]       bit_n;
   logic [7:0]       shreg_q;
   logic [7:0]       shreg_n;
   logic             tx_n;
   logic             pop;

   // TX FIFO
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             overflow;

   // Bus decode and status
   logic             wr_data;
   logic             wr_status;
   logic             full;
   logic             push;
   logic             busy;
   logic [8:0]       count_field;
   logic             unused_wdata;

   assign wr_data     = sel & we & (addr == 4'h0);
   assign wr_status   = sel & we & (addr == 4'h4);
   // The full test uses the pre-edge count, so a pop in the same cycle
   // does not make room for a push.
   assign full        = (count == FULL_CNT);
   assign push        = wr_data & ~full;
   assign busy        = (state != IDLE) | (count != '0);
   assign count_field = 9'(count);
   assign dout        = (sel & ~we) ?
                        {19'b0, count_field, 1'b0, overflow, full, busy} : 32'b0;
   assign unused_wdata = ^wdata[31:8];

   // FIFO storage: write-only port on push, no reset needed for contents
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wdata[7:0];
      end
   end

   // FIFO pointers, occupancy count and sticky overflow flag
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (wr_data & full) begin
            overflow <= 1'b1;
         end else if (wr_status & wdata[2]) begin
            overflow <= 1'b0;
         end
      end
   end

   // Shifter state register; tx is registered from the decoded line level
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         tx      <= 1'b1;
      end else begin
         state   <= state_n;
         div_q   <= div_n;
         bit_q   <= bit_n;
         shreg_q <= shreg_n;
         tx      <= tx_n;
      end
   end

   // Shifter next-state: IDLE always spends one cycle before a new frame
   always_comb begin
      state_n = state;
      div_n   = div_q;
      bit_n   = bit_q;
      shreg_n = shreg_q;
      pop     = 1'b0;
      tx_n    = 1'b1;
      case (state)
         IDLE: begin
            tx_n = 1'b1;
            if (count != '0) begin
               pop     = 1'b1;
               shreg_n = mem[rd_ptr];
               div_n   = '0;
               bit_n   = '0;
               state_n = START;
            end
         end
         START: begin
            tx_n = 1'b0;
            if (div_q == DIV_LAST) begin
               div_n   = '0;
               bit_n   = '0;
               state_n = DATA;
            end else begin
               div_n = div_q + DIV_W'(1);
            end
         end
         DATA: begin
            tx_n = shreg_q[0];
            if (div_q == DIV_LAST) begin
               div_n   = '0;
               shreg_n = {1'b0, shreg_q[7:1]};
               bit_n   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_n = STOP;
               end
            end else begin
               div_n = div_q + DIV_W'(1);
            end
         end
         STOP: begin
            tx_n = 1'b1;
            if (div_q == DIV_LAST) begin
               div_n   = '0;
               state_n = IDLE;
            end else begin
               div_n = div_q + DIV_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: bench for serial_tx with CLK_DIV = 4 and a 16-deep FIFO.
// A transaction-level model (byte queue plus a frame-time counter) predicts
// tx and status every cycle; a frame decoder checks bytes against exp_q.
module tb_serial_tx;

   localparam int D     = 4;
   localparam int DEPTH = 16;
   localparam int FRAME = 10 * D;

   logic        clk;
   logic        rst;
   logic        sel;
   logic        we;
   logic [3:0]  addr;
   logic [31:0] wdata;
   logic [31:0] dout;
   logic        tx;

   int n_checks = 0;
   int n_err    = 0;
   bit mon_en   = 0;

   serial_tx #(
      .CLK_DIV   (D),
      .FIFO_DEPTH(DEPTH),
      .CNT_W     (5)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .sel  (sel),
      .we   (we),
      .addr (addr),
      .wdata(wdata),
      .dout (dout),
      .tx   (tx)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] m_q[$];      // bytes waiting in the FIFO
   logic [7:0] exp_q[$];    // bytes expected on the line, in order
   int         m_busy = 0;  // cycles of the current frame still to run
   logic [7:0] m_cur  = '0;
   logic       m_ovf  = 1'b0;
   logic       m_tx   = 1'b1;

   function automatic logic [31:0] model_status();
      logic [8:0] c;
      c = 9'(m_q.size());
      return {19'b0, c, 1'b0, m_ovf, (m_q.size() == DEPTH),
              ((m_busy != 0) || (m_q.size() != 0))};
   endfunction

   always @(posedge clk) begin
      int  p;
      int  sz;
      bit  do_pop;
      if (rst) begin
         m_q.delete();
         exp_q.delete();
         m_busy = 0;
         m_ovf  = 1'b0;
         m_tx   = 1'b1;
      end else begin
         sz = m_q.size();
         // line level for the position the frame had before this edge
         if (m_busy == 0) begin
            m_tx = 1'b1;
         end else begin
            p = FRAME - m_busy;
            if (p < D)            m_tx = 1'b0;
            else if (p >= 9 * D)  m_tx = 1'b1;
            else                  m_tx = m_cur[p / D - 1];
         end
         do_pop = (m_busy == 0) && (sz != 0);
         if (m_busy > 0) m_busy--;
         if (do_pop) begin
            m_cur  = m_q.pop_front();
            m_busy = FRAME;
            exp_q.push_back(m_cur);
         end
         if (sel && we && addr == 4'h0) begin
            if (sz < DEPTH) m_q.push_back(wdata[7:0]);
            else            m_ovf = 1'b1;
         end
         if (sel && we && addr == 4'h4 && wdata[2]) m_ovf = 1'b0;
      end
   end

   // ---------------- per-cycle monitor ----------------
   always @(negedge clk) begin
      if (mon_en) begin
         check("tx_line", {31'b0, tx}, {31'b0, m_tx});
         if (!(sel && we)) check("dout", dout, sel ? model_status() : 32'h0);
      end
   end

   // ---------------- frame decoder / scoreboard ----------------
   bit         dec_act   = 0;
   int         dec_c     = 0;
   logic [7:0] dec_byte  = '0;
   int         frames    = 0;
   logic [7:0] last_byte = '0;
   bit         saw_aa    = 0;

   always @(negedge clk) begin
      int bi;
      if (rst) begin
         dec_act = 0;
      end else if (mon_en) begin
         if (!dec_act) begin
            if (tx == 1'b0) begin
               dec_act = 1;
               dec_c   = 0;
            end
         end else begin
            dec_c++;
         end
         if (dec_act && (dec_c % D == D / 2)) begin
            bi = dec_c / D;
            if (bi == 0) begin
               check("start_bit", {31'b0, tx}, 32'h0);
            end else if (bi <= 8) begin
               dec_byte[bi-1] = tx;
            end else begin
               check("stop_bit", {31'b0, tx}, 32'h1);
               check("frame_pending", 32'(exp_q.size() != 0), 32'h1);
               if (exp_q.size() != 0) check("frame_byte", {24'b0, dec_byte}, {24'b0, exp_q.pop_front()});
               frames++;
               last_byte = dec_byte;
               if (dec_byte == 8'hAA) saw_aa = 1;
               dec_act = 0;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_bus(input logic s, input logic w, input logic [3:0] a, input logic [31:0] d);
      sel   = s;
      we    = w;
      addr  = a;
      wdata = d;
   endtask

   task automatic set_idle();
      set_bus(1'b0, 1'b0, 4'h0, 32'h0);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      set_bus(1'b1, 1'b1, a, d);
      next_cycle();
      set_idle();
   endtask

   task automatic read_check(input string tag, input logic [31:0] exp);
      set_bus(1'b1, 1'b0, 4'h4, 32'h0);
      #1;
      check(tag, dout, exp);
      set_idle();
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((m_q.size() != 0 || m_busy != 0 || dec_act) && n < budget) begin
         next_cycle();
         n++;
      end
      check("idle_timeout", 32'(n < budget), 32'h1);
      next_cycle();
      next_cycle();
   endtask

   // ---------------- stimulus ----------------
   logic [3:0] bad_tab [4] = '{4'h1, 4'h2, 4'h8, 4'hC};

   initial begin
      int n;
      int r;
      int frames_before;
      set_idle();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1;

      // reset state
      check("reset_tx", {31'b0, tx}, 32'h1);
      read_check("reset_status", 32'h0);

      // single byte 0x55: tx falls two edges after the write edge
      bus_write(4'h0, 32'h0000_0055);
      check("tx_after_push", {31'b0, tx}, 32'h1);
      next_cycle();
      check("tx_at_pop", {31'b0, tx}, 32'h1);
      next_cycle();
      check("tx_start", {31'b0, tx}, 32'h0);
      wait_idle(200);
      check("byte_55", {24'b0, last_byte}, 32'h55);
      read_check("idle_after_55", 32'h0);

      // three back-to-back writes
      bus_write(4'h0, 32'h41);
      bus_write(4'h0, 32'h42);
      bus_write(4'h0, 32'h43);
      read_check("count_two", 32'h0000_0021);
      wait_idle(400);
      check("byte_43", {24'b0, last_byte}, 32'h43);
      read_check("idle_after_abc", 32'h0);

      // fill FIFO while busy, then overflow with 0xAA
      bus_write(4'h0, 32'h10);
      next_cycle();
      for (int i = 0; i < DEPTH; i++) bus_write(4'h0, 32'(8'h60 + i));
      bus_write(4'h0, 32'hAA);
      read_check("ovf_status", 32'h0000_0107);
      bus_write(4'h4, 32'h4);
      read_check("ovf_cleared", 32'h0000_0103);

      // push exactly on the cycle a full FIFO pops
      n = 0;
      while (!(m_busy == 0 && m_q.size() == DEPTH) && n < 200) begin
         next_cycle();
         n++;
      end
      check("pop_wait", 32'(n < 200), 32'h1);
      bus_write(4'h0, 32'h99);
      read_check("push_on_pop", 32'h0000_00F5);
      bus_write(4'h4, 32'h4);
      wait_idle(2000);
      check("aa_not_sent", {31'b0, saw_aa}, 32'h0);
      read_check("idle_after_fill", 32'h0);

      // reset in the middle of a frame with bytes queued
      bus_write(4'h0, 32'h0F);
      bus_write(4'h0, 32'h01);
      bus_write(4'h0, 32'h02);
      bus_write(4'h0, 32'h03);
      repeat (12) next_cycle();
      frames_before = frames;
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      check("rst_tx", {31'b0, tx}, 32'h1);
      read_check("rst_status", 32'h0);
      repeat (100) next_cycle();
      check("no_frames_after_rst", 32'(frames), 32'(frames_before));

      // read without select, and upper data bits ignored
      set_bus(1'b0, 1'b0, 4'h4, 32'h0);
      #1;
      check("nosel_dout", dout, 32'h0);
      set_idle();
      bus_write(4'h0, 32'hDEAD_BE31);
      wait_idle(200);
      check("low_byte_only", {24'b0, last_byte}, 32'h31);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2, 3: set_bus(1'b1, 1'b1, 4'h0, $urandom);
            4:          set_bus(1'b1, 1'b1, 4'h4, $urandom);
            5:          set_bus(1'b1, 1'b1, bad_tab[$urandom_range(0, 3)], $urandom);
            6, 7:       set_bus(1'b1, 1'b0, 4'($urandom_range(0, 15)), $urandom);
            default:    set_bus(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
         endcase
         next_cycle();
      end
      set_idle();
      wait_idle(3000);
      bus_write(4'h4, 32'h4);
      read_check("final_status", 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   // bounded run time
   initial begin
      #400000;
      n_err++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Memory-mapped UART transmitter that responds to the serial chip-select decoded from address nibble addr[23:20] == 4'hF.
- CPU stores push bytes into a TX FIFO. An 8N1 shifter drains the FIFO onto a single serial line.
- CPU loads return a status word on dout_serial, which feeds the data-memory read mux alongside the other peripheral read ports.

Parameters:
- CLK_DIV, 868: clock cycles per bit (100 MHz clock gives 115200 baud); legal range >= 2.
- FIFO_DEPTH, 16: TX FIFO entries; power of two, 2..256.
- CNT_W, 5: width of the occupancy count, equal to log2(FIFO_DEPTH)+1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sel  in  1  chip select from the address decoder (serial region)
- we  in  1  store strobe; valid only with sel
- addr  in  4  byte offset within the region: 0x0 = DATA, 0x4 = STATUS
- wdata  in  32  store data
- dout  out  32  read data, combinational from state
- tx  out  1  serial line, idle high

Behaviour:
- Reset (synchronous, active-high, takes effect on the clk edge):
  - FIFO empty, count = 0, overflow = 0, FSM in IDLE, tx = 1, bit counter and divider = 0.
  - Reset mid-frame aborts the frame. tx returns to 1 on the next edge and queued bytes are discarded.
- Write DATA (sel & we & addr == 0x0):
  - If count < FIFO_DEPTH, wdata[7:0] is pushed; wdata[31:8] is ignored.
  - If the FIFO is full, the byte is dropped and overflow is set (sticky).
  - The full test uses count before the edge, so a push on a full FIFO is rejected even if a pop happens in the same cycle.
- Write STATUS (sel & we & addr == 0x4): if wdata[2] = 1, overflow is cleared. All other bits are ignored.
- Writes with addr not in {0x0, 0x4} have no effect.
- Read (sel & !we), combinational, any offset:
  - dout = {19'b0, count[CNT_W-1:0] zero-extended into bits [12:4], 1'b0, overflow, full, busy}.
  - full = (count == FIFO_DEPTH).
  - busy = (FSM != IDLE) | (count != 0).
  - dout = 0 when sel = 0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if count != 0, pop the head into the shift register, clear the divider, go to START. tx = 1.
  - START: tx = 0 for CLK_DIV cycles, then go to DATA with bit index = 0.
  - DATA: tx = shreg[0], LSB first. Every CLK_DIV cycles, shift right and increment bit index. After bit 7 completes, go to STOP.
  - STOP: tx = 1 for CLK_DIV cycles, then go to IDLE.
- Timing:
  - Each frame is exactly 10*CLK_DIV cycles from the first start-bit cycle.
  - IDLE always consumes one cycle between frames, so back-to-back frames have a 1-cycle gap of tx = 1.
- Latency: a push accepted at edge N makes count visible after N. If the FSM is idle with an empty FIFO, the pop occurs at edge N+1 and tx = 0 from edge N+2.
- tx is driven from a register (no combinational glitches). The divider is a counter from 0 to CLK_DIV-1.
- Simultaneous push and pop: count is unchanged, and pointers advance independently and wrap modulo FIFO_DEPTH.
- count never exceeds FIFO_DEPTH and never underflows.

Test Plan:
- Reset, then write DATA 0x00000055 with CLK_DIV = 4 -> tx falls 2 cycles after the write edge. Sampled at bit centres, tx = 0,1,0,1,0,1,0,1,0,1 (start, LSB-first 0x55, stop). Frame length is 40 cycles, then busy = 0.
- Write 0x41, 0x42, 0x43 in consecutive cycles -> STATUS reads count 2 while the first byte shifts. Three frames appear in order, separated by 1-cycle idle gaps. Final status = 0x00000000.
- Fill a 16-deep FIFO while the shifter is busy, then write 0xAA -> STATUS bit1 = 1, bit2 = 1, count field = 16. 0xAA never appears on tx. Write STATUS 0x4 clears bit2 only.
- Push on the exact cycle the FSM pops from a full FIFO -> push rejected, overflow set, count goes 16 -> 15.
- Assert rst for 1 cycle mid-DATA of byte 0x0F with 3 bytes queued -> next cycle tx = 1, status = 0, and no further frames are sent.
- Read with sel = 0 -> dout = 0. Write wdata = 0xDEADBE31 -> only 0x31 is transmitted.
